load_store_unit: RTL and testbench

//  Parametrised data-memory access unit between the execute stage and the data bus.

---
 rtl/load_store_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: store lane alignment, load extension, word-aligned req/ack bus.
// Optional MISALIGNED_SPLIT_EN splits word-crossing accesses instead of trapping them.
module load_store_unit #(
    parameter int REG_WIDTH_IN_BYTE = 4,
    parameter int REG_WIDTH_IN_BIT  = REG_WIDTH_IN_BYTE * 8,
    parameter int ADDR_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_store,
    input  logic [2:0]                   req_funct3,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [REG_WIDTH_IN_BIT-1:0]  req_wdata,
    output logic                         resp_valid,
    output logic [REG_WIDTH_IN_BIT-1:0]  resp_data,
    output logic                         resp_err,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [REG_WIDTH_IN_BIT-1:0]  mem_wdata,
    output logic [REG_WIDTH_IN_BYTE-1:0] mem_wstrb,
    input  logic [REG_WIDTH_IN_BIT-1:0]  mem_rdata,
    input  logic                         mem_ack
);
    localparam int B  = REG_WIDTH_IN_BYTE;
    localparam int W  = REG_WIDTH_IN_BIT;
    localparam int OW = $clog2(B);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t state_q, state_d;

    logic [2:0]            funct3_q;
    logic [OW-1:0]         off_q;
    logic                  accept;
    logic [3:0]            req_size;
    logic                  req_illegal;
    logic                  req_trap;
    logic [OW-1:0]         req_off;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [B-1:0]          req_mask;
    logic [W-1:0]          st_lo_data;
    logic [B-1:0]          st_lo_strb;

    logic [W-1:0]          ld_raw;
    logic [W-1:0]          ld_mask;
    logic [W-1:0]          ld_ext;
    logic                  ld_sign;

    logic                  req_ready_d;
    logic                  resp_valid_d;
    logic                  resp_err_d;
    logic [W-1:0]          resp_data_d;
    logic                  mem_req_d;
    logic                  mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [W-1:0]          mem_wdata_d;
    logic [B-1:0]          mem_wstrb_d;
    logic                  done;

    assign accept   = req_valid && req_ready;
    assign req_off  = req_addr[OW-1:0];
    assign req_word = {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
    assign req_mask = B'((16'd1 << req_size) - 16'd1);

    // 011 (LD/SD) and 110 (LWU) only exist on a 64-bit datapath
    assign req_illegal = (req_funct3 == 3'b111) ||
                         ((B == 4) && (req_funct3 == 3'b011 ||
                                       req_funct3 == 3'b110));

    always_comb begin
        req_size = 4'd8;
        unique case (req_funct3[1:0])
            2'b00:   req_size = 4'd1;
            2'b01:   req_size = 4'd2;
            2'b10:   req_size = 4'd4;
            default: req_size = 4'd8;
        endcase
    end

`ifdef MISALIGNED_SPLIT_EN
    logic [2*W-1:0] st_data;
    logic [2*B-1:0] st_strb;
    logic           req_cross;
    logic           cross_q;
    logic [W-1:0]   hi_data_q;
    logic [B-1:0]   hi_strb_q;
    logic [W-1:0]   rdata0_q;

    assign st_data    = {{W{1'b0}}, req_wdata} << {req_off, 3'b000};
    assign st_strb    = {{B{1'b0}}, req_mask} << req_off;
    assign st_lo_data = st_data[W-1:0];
    assign st_lo_strb = st_strb[B-1:0];
    assign req_cross  = (5'(req_off) + 5'(req_size)) > 5'(B);
    assign req_trap   = 1'b0;

    always_comb begin
        ld_raw = '0;
        if (state_q == ACC1)
            ld_raw = W'({mem_rdata, rdata0_q} >> {off_q, 3'b000});
        else
            ld_raw = mem_rdata >> {off_q, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cross_q   <= 1'b0;
            hi_data_q <= '0;
            hi_strb_q <= '0;
            rdata0_q  <= '0;
        end else begin
            if (accept) begin
                cross_q   <= req_cross;
                hi_data_q <= st_data[2*W-1:W];
                hi_strb_q <= st_strb[2*B-1:B];
            end
            if (state_q == ACC0 && mem_ack)
                rdata0_q <= mem_rdata;
        end
    end
`else
    assign st_lo_data = req_wdata << {req_off, 3'b000};
    assign st_lo_strb = req_mask << req_off;
    assign req_trap   = (req_addr[2:0] & 3'(req_size - 4'd1)) != 3'd0;
    assign ld_raw     = mem_rdata >> {off_q, 3'b000};
`endif

    always_comb begin
        ld_mask = '1;
        ld_sign = 1'b0;
        unique case (funct3_q[1:0])
            2'b00: begin
                ld_mask = W'(8'hFF);
                ld_sign = ld_raw[7];
            end
            2'b01: begin
                ld_mask = W'(16'hFFFF);
                ld_sign = ld_raw[15];
            end
            2'b10: begin
                ld_mask = W'(32'hFFFF_FFFF);
                ld_sign = ld_raw[31];
            end
            default: begin
                ld_mask = '1;
                ld_sign = ld_raw[W-1];
            end
        endcase
        ld_ext = (ld_raw & ld_mask) |
                 ((!funct3_q[2] && ld_sign) ? ~ld_mask : '0);
    end

    always_comb begin
        state_d      = state_q;
        done         = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_wstrb_d  = mem_wstrb;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_illegal || req_trap) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACC0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_store;
                        mem_addr_d  = req_word;
                        mem_wdata_d = req_store ? st_lo_data : '0;
                        mem_wstrb_d = req_store ? st_lo_strb : '0;
                    end
                end
            end
            ACC0: begin
                if (mem_ack) begin
                    done = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
                    if (cross_q) begin
                        done        = 1'b0;
                        state_d     = ACC1;
                        mem_addr_d  = mem_addr + ADDR_WIDTH'(B);
                        mem_wdata_d = mem_we ? hi_data_q : '0;
                        mem_wstrb_d = mem_we ? hi_strb_q : '0;
                    end
`endif
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            ACC1: done = mem_ack;
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = mem_we ? '0 : ld_ext;
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            mem_addr_d   = '0;
            mem_wdata_d  = '0;
            mem_wstrb_d  = '0;
        end
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_data  <= resp_data_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_wstrb  <= mem_wstrb_d;
            if (accept) begin
                funct3_q <= req_funct3;
                off_q    <= req_off;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios on 32- and 64-bit instances
// plus random traffic against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        d_req_valid, d_req_ready, d_req_store;
    logic [2:0]  d_req_funct3;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic        d_resp_valid, d_resp_err;
    logic [63:0] d_resp_data;
    logic        d_mem_req, d_mem_we, d_mem_ack;
    logic [31:0] d_mem_addr;
    logic [63:0] d_mem_wdata, d_mem_rdata;
    logic [7:0]  d_mem_wstrb;

    int errors = 0;
    int checks = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    load_store_unit #(.REG_WIDTH_IN_BYTE(8)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(d_req_valid), .req_ready(d_req_ready),
        .req_store(d_req_store), .req_funct3(d_req_funct3),
        .req_addr(d_req_addr), .req_wdata(d_req_wdata),
        .resp_valid(d_resp_valid), .resp_data(d_resp_data),
        .resp_err(d_resp_err),
        .mem_req(d_mem_req), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
        .mem_wdata(d_mem_wdata), .mem_wstrb(d_mem_wstrb),
        .mem_rdata(d_mem_rdata), .mem_ack(d_mem_ack)
    );

    // bus_mem is what the DUT's bus writes touch; ref_mem is the model's view
    logic [7:0]  bus_mem [int unsigned];
    logic [7:0]  ref_mem [int unsigned];
    bit          auto_ack;
    int unsigned ack_delay;
    logic [31:0] log_addr  [$];
    logic [31:0] log_wdata [$];
    logic [3:0]  log_strb  [$];
    logic        log_we    [$];

    function automatic logic [7:0] bus_byte(input int unsigned a);
        return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int unsigned op_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit op_err32(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b111 || f3 == 3'b011 || f3 == 3'b110) return 1'b1;
        if (!SPLIT && (a % op_size(f3)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [63:0] v;
        int n;
        v = '0;
        n = int'(op_size(f3));
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + 32'(i));
        if (!f3[2] && v[8*n-1])
            for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        return v[31:0];
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            bus_mem[a + 32'(i)] = w[8*i +: 8];
            ref_mem[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        ack_delay = 0;
        forever begin
            @(negedge clk);
            if (auto_ack) begin
                mem_ack = 1'b0;
                mem_rdata = '0;
                if (mem_req && !reset) begin
                    if (ack_delay == 0) begin
                        mem_ack = 1'b1;
                        for (int i = 0; i < 4; i++)
                            mem_rdata[8*i +: 8] = bus_byte(mem_addr + 32'(i));
                        log_addr.push_back(mem_addr);
                        log_wdata.push_back(mem_wdata);
                        log_strb.push_back(mem_wstrb);
                        log_we.push_back(mem_we);
                        if (mem_we)
                            for (int i = 0; i < 4; i++)
                                if (mem_wstrb[i])
                                    bus_mem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
                        ack_delay = $urandom_range(0, 2);
                    end else begin
                        ack_delay = ack_delay - 1;
                    end
                end
            end
        end
    end

    task automatic send(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL send_ready got=%0b want=1", req_ready);
        end
        log_addr.delete();
        log_wdata.delete();
        log_strb.delete();
        log_we.delete();
        req_valid = 1'b1;
        req_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr = $urandom;
    endtask

    task automatic run_op(input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output bit got, output int lat,
                          output logic [31:0] d, output logic e);
        send(st, f3, a, wd);
        lat = 0;
        while (!resp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        got = resp_valid;
        d = resp_data;
        e = resp_err;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_pulse_width resp_valid=%0b want=0", resp_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%0b want=1", req_ready);
        end
        checks++;
        if ({resp_valid, resp_err, resp_data} !== 34'd0) begin
            errors++;
            $display("FAIL reset_resp got=%0b/%0b/%h want=0/0/0", resp_valid, resp_err, resp_data);
        end
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== 70'd0) begin
            errors++;
            $display("FAIL reset_bus req=%0b we=%0b addr=%h wd=%h strb=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        checks++;
        if ({d_req_ready, d_mem_req, d_resp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_w64 ready/req/valid=%b want=100",
                     {d_req_ready, d_mem_req, d_resp_valid});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lb_sign();
        bit got; int lat; logic [31:0] d; logic e;
        put_word(32'h100, 32'h8000_0000);
        ack_delay = 0;
        run_op(1'b0, 3'b000, 32'h103, 32'h0, got, lat, d, e);
        checks++;
        if (!got || e !== 1'b0 || d !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_sign got=%0b err=%0b data=%h want 1/0/ffffff80", got, e, d);
        end
        checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 32'h100) begin
            errors++;
            $display("FAIL lb_bus n=%0d want one access @100", log_addr.size());
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL lb_latency got=%0d want=1", lat);
        end
    endtask

    task automatic test_half();
        bit got; int lat; logic [31:0] d; logic e;
        put_word(32'h100, 32'hBEEF_1234);
        run_op(1'b0, 3'b101, 32'h102, 32'h0, got, lat, d, e);
        checks++;
        if (!got || e !== 1'b0 || d !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL lhu got=%0b err=%0b data=%h want 1/0/0000beef", got, e, d);
        end
        run_op(1'b0, 3'b001, 32'h100, 32'h0, got, lat, d, e);
        checks++;
        if (!got || e !== 1'b0 || d !== 32'h0000_1234) begin
            errors++;
            $display("FAIL lh_pos got=%0b err=%0b data=%h want 1/0/00001234", got, e, d);
        end
        run_op(1'b0, 3'b001, 32'h102, 32'h0, got, lat, d, e);
        checks++;
        if (!got || e !== 1'b0 || d !== 32'hFFFF_BEEF) begin
            errors++;
            $display("FAIL lh_neg got=%0b err=%0b data=%h want 1/0/ffffbeef", got, e, d);
        end
    endtask

    task automatic test_store_align();
        bit got; int lat; logic [31:0] d; logic e;
        put_word(32'h100, 32'h0);
        run_op(1'b1, 3'b001, 32'h101, 32'h0000_ABCD, got, lat, d, e);
        checks++;
        if (!got || e !== !SPLIT || d !== 32'h0) begin
            errors++;
            $display("FAIL sh_resp got=%0b err=%0b data=%h want 1/%0b/0", got, e, d, !SPLIT);
        end
        checks++;
        if (log_addr.size() != (SPLIT ? 1 : 0)) begin
            errors++;
            $display("FAIL sh_count got=%0d want=%0d", log_addr.size(), SPLIT ? 1 : 0);
        end
        if (log_addr.size() == 1) begin
            checks++;
            if (log_wdata[0] !== 32'h00AB_CD00 || log_strb[0] !== 4'b0110 || log_we[0] !== 1'b1) begin
                errors++;
                $display("FAIL sh_lanes wd=%h strb=%b we=%0b want 00abcd00/0110/1",
                         log_wdata[0], log_strb[0], log_we[0]);
            end
        end
        if (!e) for (int i = 0; i < 2; i++) ref_mem[32'h101 + 32'(i)] = (i == 0) ? 8'hCD : 8'hAB;
    endtask

    task automatic test_split_load();
        bit got; int lat; logic [31:0] d; logic e;
        put_word(32'h104, 32'hDDCC_BBAA);
        put_word(32'h108, 32'h4433_2211);
        run_op(1'b0, 3'b010, 32'h106, 32'h0, got, lat, d, e);
        checks++;
        if (!got || e !== !SPLIT || d !== (SPLIT ? 32'h2211_DDCC : 32'h0)) begin
            errors++;
            $display("FAIL lw_cross got=%0b err=%0b data=%h", got, e, d);
        end
        checks++;
        if (log_addr.size() != (SPLIT ? 2 : 0)) begin
            errors++;
            $display("FAIL lw_cross_count got=%0d want=%0d", log_addr.size(), SPLIT ? 2 : 0);
        end
        if (log_addr.size() == 2) begin
            checks++;
            if (log_addr[0] !== 32'h104 || log_addr[1] !== 32'h108) begin
                errors++;
                $display("FAIL lw_cross_addr got=%h,%h want=104,108", log_addr[0], log_addr[1]);
            end
        end
    endtask

    task automatic test_reset_abandon();
        bit seen;
        auto_ack = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        send(1'b0, 3'b010, 32'h100, 32'h0);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL abandon_req got=%0b want=1", mem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abandon_reset req=%0b ready=%0b want 0/1", mem_req, req_ready);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            if (resp_valid || mem_req) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abandon_late_ack resp/req seen=1 want=0");
        end
        auto_ack = 1'b1;
    endtask

    task automatic op64(input logic [2:0] f3, input logic [31:0] a, input logic [63:0] rd,
                        output bit got, output int lat, output logic [63:0] d,
                        output logic e, output int nreq, output logic [31:0] first_addr);
        got = 1'b0;
        lat = 0;
        nreq = 0;
        d = '0;
        e = 1'b0;
        first_addr = '0;
        d_req_valid = 1'b1;
        d_req_store = 1'b0;
        d_req_funct3 = f3;
        d_req_addr = a;
        @(negedge clk);
        d_req_valid = 1'b0;
        while (!got && lat < 20) begin
            d_mem_ack = 1'b0;
            if (d_resp_valid) begin
                got = 1'b1;
                d = d_resp_data;
                e = d_resp_err;
            end else begin
                if (d_mem_req) begin
                    if (nreq == 0) first_addr = d_mem_addr;
                    nreq++;
                    d_mem_ack = 1'b1;
                    d_mem_rdata = rd;
                end
                @(negedge clk);
                lat++;
            end
        end
        d_mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_w64();
        bit got; int lat; logic [63:0] d; logic e; int n; logic [31:0] fa;
        logic [63:0] rd;
        op64(3'b110, 32'h8, 64'h0000_0000_F000_0001, got, lat, d, e, n, fa);
        checks++;
        if (!got || e !== 1'b0 || d !== 64'h0000_0000_F000_0001 || n != 1 || fa !== 32'h8) begin
            errors++;
            $display("FAIL w64_lwu got=%0b err=%0b data=%h n=%0d addr=%h", got, e, d, n, fa);
        end
        op64(3'b010, 32'hC, 64'h8000_0000_1234_5678, got, lat, d, e, n, fa);
        checks++;
        if (!got || e !== 1'b0 || d !== 64'hFFFF_FFFF_8000_0000 || fa !== 32'h8) begin
            errors++;
            $display("FAIL w64_lw got=%0b err=%0b data=%h addr=%h", got, e, d, fa);
        end
        rd = {$urandom, $urandom};
        op64(3'b011, 32'h10, rd, got, lat, d, e, n, fa);
        checks++;
        if (!got || e !== 1'b0 || d !== rd) begin
            errors++;
            $display("FAIL w64_ld got=%0b err=%0b data=%h want=%h", got, e, d, rd);
        end
        op64(3'b111, 32'h8, 64'h0, got, lat, d, e, n, fa);
        checks++;
        if (!got || e !== 1'b1 || n != 0 || lat > 1 || d !== 64'h0) begin
            errors++;
            $display("FAIL w64_illegal got=%0b err=%0b n=%0d lat=%0d data=%h", got, e, n, lat, d);
        end
    endtask

    task automatic test_random();
        bit got; int lat; logic [31:0] d; logic e;
        logic st; logic [2:0] f3; logic [31:0] a, wd, exp_d;
        int pick, exp_n;
        bit exp_e;
        for (int k = 0; k < 40; k++) put_word(32'h100 + 32'(4 * k), $urandom);
        for (int k = 0; k < 120; k++) begin
            st = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 99);
            if (pick < 4) f3 = 3'b111;
            else if (pick < 7) f3 = 3'b011;
            else if (pick < 9 && !st) f3 = 3'b110;
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                pick = $urandom_range(0, 4);
                f3 = 3'(pick < 3 ? pick : pick + 1);
            end
            a = 32'h100 + 32'($urandom_range(0, 120));
            if ($urandom_range(0, 1) == 1) a = a & ~(op_size(f3) - 1);
            wd = $urandom;
            exp_e = op_err32(f3, a);
            exp_d = (st || exp_e) ? 32'h0 : model_load(f3, a);
            exp_n = exp_e ? 0 : (((a % 4) + op_size(f3) > 4) ? 2 : 1);
            run_op(st, f3, a, wd, got, lat, d, e);
            checks++;
            if (!got || e !== exp_e || d !== exp_d) begin
                errors++;
                $display("FAIL rand_resp op=%0d st=%0b f3=%0d a=%h got=%0b err=%0b data=%h want err=%0b data=%h",
                         k, st, f3, a, got, e, d, exp_e, exp_d);
            end
            checks++;
            if (log_addr.size() != exp_n) begin
                errors++;
                $display("FAIL rand_count op=%0d a=%h got=%0d want=%0d", k, a, log_addr.size(), exp_n);
            end
            if (log_addr.size() > 0) begin
                checks++;
                if (log_addr[0] !== (a & ~32'h3) || log_we[0] !== st ||
                    (!st && log_strb[0] !== 4'b0)) begin
                    errors++;
                    $display("FAIL rand_bus op=%0d addr=%h we=%0b strb=%b want addr=%h we=%0b",
                             k, log_addr[0], log_we[0], log_strb[0], a & ~32'h3, st);
                end
            end
            if (st && !exp_e)
                for (int i = 0; i < int'(op_size(f3)); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        end
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 32'h100; i < 32'h180; i++)
            if (bus_byte(i) !== ref_byte(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mem_image mismatched_bytes=%0d want=0", bad);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        auto_ack = 1'b1;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = '0;
        req_addr = '0;
        req_wdata = '0;
        d_req_valid = 1'b0;
        d_req_store = 1'b0;
        d_req_funct3 = '0;
        d_req_addr = '0;
        d_req_wdata = '0;
        d_mem_ack = 1'b0;
        d_mem_rdata = '0;
        test_reset();
        test_lb_sign();
        test_half();
        test_store_align();
        test_split_load();
        test_reset_abandon();
        test_w64();
        test_random();
        test_memory_image();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
